regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: A (ALU path) and B (memory path).
- Each requester has a valid/ready handshake into a 1-entry holding slot.
- Slots drain into the register file write port (WriteReg, DstReg, DstData) one write per cycle, oldest entry first.
- Exports a 16-bit pending-write mask and two read-hazard flags, used by the decode stage to stall on SrcReg1/SrcReg2.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/wb_slot.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_AW = 4;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              full;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } wb_grant_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: latches an accepted request and frees itself
// when its write is granted, unless refilled on that same edge.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int REG_AW = regfile_pkg::REG_AW,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              grant,
  input  logic [REG_AW-1:0] req_reg,
  input  logic [DATA_W-1:0] req_data,
  output logic              ready,
  output logic              load,
  output logic              full,
  output logic [REG_AW-1:0] entry_dst,
  output logic [DATA_W-1:0] entry_data
);

  // A draining slot can take a new entry in the same cycle, giving one write per cycle.
  assign ready = !full || grant;
  assign load  = valid && ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only observed while full is set,
  // so clearing it would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (load) begin
      entry_dst  <= req_reg;
      entry_data <= req_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the single register-file write port,
// oldest entry first, and publishes pending-write busy/hazard information.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W    = regfile_pkg::DATA_W,
  parameter int REG_AW    = regfile_pkg::REG_AW,
  parameter bit TIE_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_AW-1:0]      a_reg,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_AW-1:0]      b_reg,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   WriteReg,
  output logic [REG_AW-1:0]      DstReg,
  output logic [DATA_W-1:0]      DstData,
  input  logic [REG_AW-1:0]      SrcReg1,
  input  logic [REG_AW-1:0]      SrcReg2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic [2**REG_AW-1:0]   busy_mask
);

  wb_grant_t         grant;
  logic              grant_a, grant_b;
  logic              a_load, b_load, a_full, b_full;
  logic [REG_AW-1:0] a_dst, b_dst;
  logic [DATA_W-1:0] a_held, b_held;
  logic              a_older;
  logic              tie_ptr;
  logic              tie;

  assign grant_a = (grant == GNT_A);
  assign grant_b = (grant == GNT_B);

  wb_slot #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .valid      (a_valid),
    .grant      (grant_a),
    .req_reg    (a_reg),
    .req_data   (a_data),
    .ready      (a_ready),
    .load       (a_load),
    .full       (a_full),
    .entry_dst  (a_dst),
    .entry_data (a_held)
  );

  wb_slot #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .valid      (b_valid),
    .grant      (grant_b),
    .req_reg    (b_reg),
    .req_data   (b_data),
    .ready      (b_ready),
    .load       (b_load),
    .full       (b_full),
    .entry_dst  (b_dst),
    .entry_data (b_held)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (a_full && b_full) begin
      grant = a_older ? GNT_A : GNT_B;
    end else if (a_full) begin
      grant = GNT_A;
    end else if (b_full) begin
      grant = GNT_B;
    end
  end

  always_comb begin
    WriteReg = 1'b0;
    DstReg   = '0;
    DstData  = '0;
    case (grant)
      GNT_A: begin
        WriteReg = 1'b1;
        DstReg   = a_dst;
        DstData  = a_held;
      end
      GNT_B: begin
        WriteReg = 1'b1;
        DstReg   = b_dst;
        DstData  = b_held;
      end
      default: ;
    endcase
  end

  assign tie = a_load && b_load && !a_full && !b_full;

  // A slot that stays occupied across the edge is always older than a fresh
  // load into the other slot; a double load with one slot refilling treats the
  // previously empty slot as older.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_older <= 1'b0;
      tie_ptr <= TIE_FIRST;
    end else if (tie) begin
      a_older <= (tie_ptr == 1'b0);
      tie_ptr <= ~tie_ptr;
    end else if (a_load && b_load) begin
      a_older <= !a_full;
    end else if (a_load) begin
      a_older <= !(b_full && !grant_b);
    end else if (b_load) begin
      a_older <= a_full && !grant_a;
    end
  end

  always_comb begin
    busy_mask = '0;
    if (a_full) busy_mask[a_dst] = 1'b1;
    if (b_full) busy_mask[b_dst] = 1'b1;
  end

  assign hazard1 = busy_mask[SrcReg1];
  assign hazard2 = busy_mask[SrcReg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against an in-order queue model of
// pending writes for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_reg, b_reg;
  logic [15:0] a_data, b_data;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1, SrcReg2;
  logic        hazard1, hazard2;
  logic [15:0] busy_mask;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf [16];

  typedef struct {
    bit          owner;  // 0 = A, 1 = B
    logic [3:0]  dst;
    logic [15:0] data;
  } mentry_t;

  mentry_t q[$];
  bit      m_tie;

  regfile_wb_arbiter #(.DATA_W(16), .REG_AW(4), .TIE_FIRST(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  // Register file image built from what the DUT actually writes.
  always @(posedge clk) begin
    if (!rst && WriteReg) rf[DstReg] <= DstData;
  end

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    SrcReg1 = '0; SrcReg2 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", WriteReg); end
    total++; if (DstReg !== 4'd0 || DstData !== 16'd0) begin bad++; $display("FAIL reset_dst got=%h/%h want=0/0", DstReg, DstData); end
    total++; if (busy_mask !== 16'h0) begin bad++; $display("FAIL reset_busy got=%h want=0000", busy_mask); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b want=11", a_ready, b_ready); end
    total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b%b want=00", hazard1, hazard2); end
  endtask

  task automatic test_single();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
    @(negedge clk);
    a_valid = 1'b0; SrcReg1 = 4'd3;
    #1;
    total++; if (WriteReg !== 1'b1 || DstReg !== 4'd3 || DstData !== 16'h1234) begin
      bad++; $display("FAIL single_write got=%b/%0d/%h want=1/3/1234", WriteReg, DstReg, DstData); end
    total++; if (busy_mask !== 16'h0008) begin bad++; $display("FAIL single_busy got=%h want=0008", busy_mask); end
    total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL single_hazard1 got=%b want=1", hazard1); end
    @(negedge clk);
    #1;
    total++; if (busy_mask !== 16'h0 || WriteReg !== 1'b0) begin
      bad++; $display("FAIL single_drained got=%h/%b want=0000/0", busy_mask, WriteReg); end
    total++; if (rf[3] !== 16'h1234) begin bad++; $display("FAIL single_rf got=%h want=1234", rf[3]); end
    SrcReg1 = '0;
  endtask

  task automatic test_stream();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        total++; if (WriteReg !== 1'b1 || DstReg !== 4'(i)) begin
          bad++; $display("FAIL stream_write%0d got=%b/%0d want=1/%0d", i, WriteReg, DstReg, i); end
      end
      if (i < 4) begin
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b want=1", i, a_ready); end
        a_valid = 1'b1; a_reg = 4'(i + 1); a_data = 16'(16'h100 + i);
      end else begin
        a_valid = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", WriteReg); end
  endtask

  task automatic tie_round(input logic [15:0] first, input logic [15:0] second, input int round);
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'hAAAA;
    b_valid = 1'b1; b_reg = 4'd5; b_data = 16'hBBBB;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    total++; if (WriteReg !== 1'b1 || DstReg !== 4'd5 || DstData !== first) begin
      bad++; $display("FAIL tie%0d_first got=%b/%0d/%h want=1/5/%h", round, WriteReg, DstReg, DstData, first); end
    total++; if (busy_mask !== 16'h0020) begin bad++; $display("FAIL tie%0d_busy1 got=%h want=0020", round, busy_mask); end
    @(negedge clk);
    #1;
    total++; if (WriteReg !== 1'b1 || DstData !== second) begin
      bad++; $display("FAIL tie%0d_second got=%b/%h want=1/%h", round, WriteReg, DstData, second); end
    total++; if (busy_mask !== 16'h0020) begin bad++; $display("FAIL tie%0d_busy2 got=%h want=0020", round, busy_mask); end
    @(negedge clk);
    #1;
    total++; if (busy_mask !== 16'h0 || WriteReg !== 1'b0) begin
      bad++; $display("FAIL tie%0d_drained got=%h/%b want=0000/0", round, busy_mask, WriteReg); end
    total++; if (rf[5] !== second) begin bad++; $display("FAIL tie%0d_rf5 got=%h want=%h", round, rf[5], second); end
  endtask

  task automatic test_tie();
    tie_round(16'hAAAA, 16'hBBBB, 0);
    tie_round(16'hBBBB, 16'hAAAA, 1);
  endtask

  task automatic test_refill_order();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd7; a_data = 16'h0007;
    @(negedge clk);
    #1;
    total++; if (WriteReg !== 1'b1 || DstReg !== 4'd7) begin bad++; $display("FAIL refill_w7 got=%b/%0d want=1/7", WriteReg, DstReg); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("FAIL refill_ready1 got=%b%b want=11", a_ready, b_ready); end
    a_reg = 4'd9; a_data = 16'h0009;
    b_valid = 1'b1; b_reg = 4'd8; b_data = 16'h0008;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    total++; if (WriteReg !== 1'b1 || DstReg !== 4'd8 || DstData !== 16'h0008) begin
      bad++; $display("FAIL refill_w8 got=%b/%0d/%h want=1/8/0008", WriteReg, DstReg, DstData); end
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin bad++; $display("FAIL refill_ready2 got=%b%b want=01", a_ready, b_ready); end
    @(negedge clk);
    #1;
    total++; if (WriteReg !== 1'b1 || DstReg !== 4'd9) begin bad++; $display("FAIL refill_w9 got=%b/%0d want=1/9", WriteReg, DstReg); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("FAIL refill_ready3 got=%b%b want=11", a_ready, b_ready); end
    @(negedge clk);
    #1;
    total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL refill_end got=%b want=0", WriteReg); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd2;  a_data = 16'h0202;
    b_valid = 1'b1; b_reg = 4'd14; b_data = 16'h0E0E;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    SrcReg1 = 4'd14; SrcReg2 = 4'd6;
    #1;
    total++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin bad++; $display("FAIL hazard_pair got=%b%b want=10", hazard1, hazard2); end
    total++; if (busy_mask !== 16'h4004) begin bad++; $display("FAIL hazard_busy got=%h want=4004", busy_mask); end
    SrcReg2 = 4'd2;
    #1;
    total++; if (hazard2 !== 1'b1) begin bad++; $display("FAIL hazard_src2 got=%b want=1", hazard2); end
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (busy_mask !== 16'h0 || hazard1 !== 1'b0) begin bad++; $display("FAIL hazard_clear got=%h/%b want=0000/0", busy_mask, hazard1); end
    SrcReg1 = '0; SrcReg2 = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_valid = 1'b1; a_reg = 4'd11; a_data = 16'hDEAD;
    b_valid = 1'b1; b_reg = 4'd12; b_data = 16'hBEEF;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (WriteReg !== 1'b0 || DstReg !== 4'd0 || DstData !== 16'd0) begin
      bad++; $display("FAIL rstmid_port got=%b/%0d/%h want=0/0/0000", WriteReg, DstReg, DstData); end
    total++; if (busy_mask !== 16'h0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_state got=%h/%b%b want=0000/11", busy_mask, a_ready, b_ready); end
    @(negedge clk);
    #1;
    total++; if (WriteReg !== 1'b0) begin bad++; $display("FAIL rstmid_nowrite got=%b want=0", WriteReg); end
  endtask

  function automatic bit m_has(input bit owner);
    foreach (q[i]) if (q[i].owner == owner) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input bit owner);
    return !m_has(owner) || (q.size() > 0 && q[0].owner == owner);
  endfunction

  task automatic test_random();
    logic        e_we, e_ra, e_rb;
    logic [3:0]  e_dst;
    logic [15:0] e_data, e_busy;
    bit          pre_a, pre_b, la, lb;
    mentry_t     ea, eb;
    apply_reset();
    q.delete();
    m_tie = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a_valid = ($urandom_range(0, 9) < 6);
      b_valid = ($urandom_range(0, 9) < 6);
      a_reg = 4'($urandom_range(0, 15)); a_data = 16'($urandom);
      b_reg = 4'($urandom_range(0, 15)); b_data = 16'($urandom);
      SrcReg1 = 4'($urandom_range(0, 15)); SrcReg2 = 4'($urandom_range(0, 15));
      #1;
      e_we   = (q.size() > 0);
      e_dst  = e_we ? q[0].dst : 4'd0;
      e_data = e_we ? q[0].data : 16'd0;
      e_busy = '0;
      foreach (q[i]) e_busy[q[i].dst] = 1'b1;
      e_ra = m_ready(1'b0);
      e_rb = m_ready(1'b1);
      total++; if (WriteReg !== e_we || DstReg !== e_dst || DstData !== e_data) begin
        bad++; $display("FAIL rnd_port c=%0d got=%b/%0d/%h want=%b/%0d/%h", c, WriteReg, DstReg, DstData, e_we, e_dst, e_data); end
      total++; if (a_ready !== e_ra || b_ready !== e_rb) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b%b want=%b%b", c, a_ready, b_ready, e_ra, e_rb); end
      total++; if (busy_mask !== e_busy) begin
        bad++; $display("FAIL rnd_busy c=%0d got=%h want=%h", c, busy_mask, e_busy); end
      total++; if (hazard1 !== e_busy[SrcReg1] || hazard2 !== e_busy[SrcReg2]) begin
        bad++; $display("FAIL rnd_hazard c=%0d got=%b%b want=%b%b", c, hazard1, hazard2, e_busy[SrcReg1], e_busy[SrcReg2]); end
      // Advance the model across the coming edge: retire the oldest write, then enqueue accepts.
      pre_a = m_has(1'b0);
      pre_b = m_has(1'b1);
      la = a_valid && e_ra;
      lb = b_valid && e_rb;
      ea = '{owner: 1'b0, dst: a_reg, data: a_data};
      eb = '{owner: 1'b1, dst: b_reg, data: b_data};
      if (q.size() > 0) void'(q.pop_front());
      if (la && lb) begin
        if (!pre_a && !pre_b) begin
          if (!m_tie) begin q.push_back(ea); q.push_back(eb); end
          else        begin q.push_back(eb); q.push_back(ea); end
          m_tie = !m_tie;
        end else if (!pre_a) begin
          q.push_back(ea); q.push_back(eb);
        end else begin
          q.push_back(eb); q.push_back(ea);
        end
      end else if (la) begin
        q.push_back(ea);
      end else if (lb) begin
        q.push_back(eb);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_stream();
    test_tie();
    test_refill_order();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
